// File: rtl/ccd_capture_roi.sv
// rtl/ccd_capture_roi.sv - D5M capture front end with ROI gate, decimation and snapshot.
// Qualifies FVAL/LVAL, counts X/Y/frames and emits windowed pixels two cycles after input.
module ccd_capture_roi #(
  parameter int DATA_W       = 12,
  parameter int CNT_W        = 16,
  parameter int FRM_W        = 32,
  parameter int COLUMN_WIDTH = 1280,
  parameter int SKIP_W       = 4
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iFVAL,
  input  logic              iLVAL,
  input  logic              iSTART,
  input  logic              iEND,
  input  logic              iSNAP,
  input  logic [SKIP_W-1:0] iSKIP,
  input  logic [CNT_W-1:0]  iX_START,
  input  logic [CNT_W-1:0]  iX_END,
  input  logic [CNT_W-1:0]  iY_START,
  input  logic [CNT_W-1:0]  iY_END,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic [CNT_W-1:0]  oX_Cont,
  output logic [CNT_W-1:0]  oY_Cont,
  output logic [FRM_W-1:0]  oFrame_Cont,
  output logic              oBUSY,
  output logic              oFRAME_DONE,
  output logic              oLINE_ERR
);

  typedef enum logic [1:0] {IDLE, RUN, SNAP} mode_t;

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(COLUMN_WIDTH - 1);

  mode_t             mode;
  logic              fval_d;
  logic              m_lval;
  logic              m_lval_d;
  logic [DATA_W-1:0] m_data;
  logic [SKIP_W-1:0] skip_cnt;
  logic              snap_taken;
  logic [CNT_W-1:0]  x_cnt, y_cnt;
  logic [CNT_W-1:0]  xs, xe, ys, ye;

  logic fval_rise, fval_fall, frame_start, accept, in_win, dval_next, line_fall;

  always_comb begin
    fval_rise   = iFVAL & ~fval_d;
    fval_fall   = ~iFVAL & fval_d;
    frame_start = fval_rise && (mode != IDLE);
    accept      = frame_start && (skip_cnt == '0);
    in_win      = (x_cnt >= xs) && (x_cnt <= xe) && (y_cnt >= ys) && (y_cnt <= ye);
    dval_next   = oBUSY & m_lval & in_win;
    line_fall   = m_lval_d & ~m_lval;
  end

  // Mode and decimation control; iEND has priority over everything.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      mode       <= IDLE;
      skip_cnt   <= '0;
      snap_taken <= 1'b0;
    end else begin
      if (iEND) begin
        mode <= IDLE;
      end else begin
        case (mode)
          IDLE: begin
            if (iSTART)     mode <= RUN;
            else if (iSNAP) mode <= SNAP;
          end
          SNAP: if (oFRAME_DONE && snap_taken) mode <= IDLE;
          default: mode <= mode;
        endcase
      end

      if (mode == IDLE)
        skip_cnt <= '0;
      else if (frame_start)
        skip_cnt <= accept ? iSKIP : skip_cnt - 1'b1;

      if (mode != SNAP)
        snap_taken <= 1'b0;
      else if (accept)
        snap_taken <= 1'b1;
    end
  end

  // The FVAL edge register resets high so a frame already running at release is ignored.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      fval_d      <= 1'b1;
      m_lval      <= 1'b0;
      m_lval_d    <= 1'b0;
      m_data      <= '0;
      oBUSY       <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oFrame_Cont <= '0;
      xs          <= '0;
      xe          <= '0;
      ys          <= '0;
      ye          <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      oLINE_ERR   <= 1'b0;
      oDVAL       <= 1'b0;
      oDATA       <= '0;
      oX_Cont     <= '0;
      oY_Cont     <= '0;
    end else begin
      fval_d      <= iFVAL;
      m_lval      <= iLVAL;
      m_lval_d    <= m_lval;
      m_data      <= iLVAL ? iDATA : '0;
      oFRAME_DONE <= 1'b0;

      if (accept) begin
        oBUSY       <= 1'b1;
        oFrame_Cont <= oFrame_Cont + 1'b1;
        xs          <= iX_START;
        xe          <= iX_END;
        ys          <= iY_START;
        ye          <= iY_END;
        x_cnt       <= '0;
        y_cnt       <= '0;
      end else if (fval_fall && oBUSY) begin
        oBUSY       <= 1'b0;
        oFRAME_DONE <= 1'b1;
        x_cnt       <= '0;
        y_cnt       <= '0;
      end else if (oBUSY) begin
        if (m_lval) begin
          if (x_cnt == X_LAST) begin
            x_cnt <= '0;
            y_cnt <= y_cnt + 1'b1;
          end else begin
            x_cnt <= x_cnt + 1'b1;
          end
        end else if (line_fall && (x_cnt != '0)) begin
          // Short line: flag it and realign to the start of the next row.
          oLINE_ERR <= 1'b1;
          x_cnt     <= '0;
          y_cnt     <= y_cnt + 1'b1;
        end
      end else begin
        x_cnt <= '0;
        y_cnt <= '0;
      end

      oDVAL   <= dval_next;
      oDATA   <= dval_next ? m_data : '0;
      oX_Cont <= x_cnt;
      oY_Cont <= y_cnt;
    end
  end

endmodule
